// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch-stage state encoding and width/reset defaults
package fetch_unit_pkg;
  localparam int DEFAULT_ADDR_WIDTH = 16;
  localparam int DEFAULT_INSTR_WIDTH = 16;
  localparam int DEFAULT_RESET_PC = 0;
  typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} fetch_state_t;
endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// fetch_unit_if_id_reg: IF/ID pipeline register with load, hold and flush
module fetch_unit_if_id_reg #(
  parameter int ADDR_WIDTH = 16,
  parameter int INSTR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   flush,
  input  logic [INSTR_WIDTH-1:0] instr_nx,
  input  logic [ADDR_WIDTH-1:0]  pc_plus1_nx,
  output logic [INSTR_WIDTH-1:0] instr_d,
  output logic [ADDR_WIDTH-1:0]  pc_plus1_d,
  output logic                   valid_d
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      instr_d <= '0;
      pc_plus1_d <= '0;
      valid_d <= 1'b0;
    end else if (load) begin
      instr_d <= instr_nx;
      pc_plus1_d <= pc_plus1_nx;
      valid_d <= 1'b1;
    end else if (flush) begin
      valid_d <= 1'b0;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, imem req/ready handshake, stall hold buffer and branch squash
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   PC_source,
  input  logic [ADDR_WIDTH-1:0]  branch_target_d,
  input  logic                   stall_f,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ready,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] instr_d,
  output logic [ADDR_WIDTH-1:0]  pc_plus1_d,
  output logic                   valid_d
);
  fetch_state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] pc, pc_nx, pc_inc, redir, redir_nx, buf_pc1;
  logic [INSTR_WIDTH-1:0] buf_instr;
  logic buf_ld, load, flush;
  assign pc_inc = pc + ADDR_WIDTH'(1);
  assign imem_req = (state == REQ) || (state == DROP);
  assign imem_addr = pc;
  assign buf_ld = (state == REQ) && imem_ready && stall_f && !PC_source;
  assign load = !PC_source && !stall_f && (((state == REQ) && imem_ready) || (state == HOLD));
  assign flush = PC_source || (!load && !stall_f);
  always_comb begin
    state_nx = state;
    pc_nx = pc;
    redir_nx = redir;
    case (state)
      IDLE: begin
        state_nx = REQ;
        pc_nx = PC_source ? branch_target_d : pc;
      end
      REQ: begin
        if (PC_source) begin
          state_nx = imem_ready ? REQ : DROP;
          pc_nx = imem_ready ? branch_target_d : pc;
          redir_nx = branch_target_d;
        end else if (imem_ready) begin
          state_nx = stall_f ? HOLD : REQ;
          pc_nx = pc_inc;
        end
      end
      HOLD: begin
        state_nx = (PC_source || !stall_f) ? REQ : HOLD;
        pc_nx = PC_source ? branch_target_d : pc;
      end
      DROP: begin
        redir_nx = PC_source ? branch_target_d : redir;
        state_nx = imem_ready ? REQ : DROP;
        pc_nx = imem_ready ? redir_nx : pc;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      redir <= '0;
      buf_instr <= '0;
      buf_pc1 <= '0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      redir <= redir_nx;
      if (PC_source) begin
        buf_instr <= '0;
        buf_pc1 <= '0;
      end else if (buf_ld) begin
        buf_instr <= imem_rdata;
        buf_pc1 <= pc_inc;
      end
    end
  fetch_unit_if_id_reg #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .INSTR_WIDTH(INSTR_WIDTH)
  ) u_if_id (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .flush(flush),
    .instr_nx((state == HOLD) ? buf_instr : imem_rdata),
    .pc_plus1_nx((state == HOLD) ? buf_pc1 : pc_inc),
    .instr_d(instr_d),
    .pc_plus1_d(pc_plus1_d),
    .valid_d(valid_d)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven directed check of fetch_unit plus async reset sequence
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic PC_source = 1'b0;
  logic [15:0] branch_target_d = '0;
  logic stall_f = 1'b0;
  logic imem_req;
  logic [15:0] imem_addr;
  logic imem_ready = 1'b0;
  logic [15:0] imem_rdata;
  logic [15:0] instr_d;
  logic [15:0] pc_plus1_d;
  logic valid_d;
  int tests = 0;
  int fails = 0;
  int row = 0;
  typedef struct {
    logic ps;
    logic [15:0] tgt;
    logic st;
    logic rdy;
    logic e_req;
    logic [15:0] e_addr;
    logic [15:0] e_instr;
    logic [15:0] e_pc1;
    logic e_val;
  } vec_t;
  vec_t vecs[29];
  always #5 clk = ~clk;
  function automatic logic [15:0] w(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction
  assign imem_rdata = imem_ready ? w(imem_addr) : 16'hDEAD;
  fetch_unit dut (
    .clk(clk),
    .rst_n(rst_n),
    .PC_source(PC_source),
    .branch_target_d(branch_target_d),
    .stall_f(stall_f),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .instr_d(instr_d),
    .pc_plus1_d(pc_plus1_d),
    .valid_d(valid_d)
  );
  function automatic vec_t mk(input logic ps, input logic [15:0] tgt, input logic st, input logic rdy,
                              input logic e_req, input logic [15:0] e_addr, input logic [15:0] e_instr,
                              input logic [15:0] e_pc1, input logic e_val);
    vec_t v;
    v.ps = ps; v.tgt = tgt; v.st = st; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_instr = e_instr; v.e_pc1 = e_pc1; v.e_val = e_val;
    return v;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s step %0d: got %0h want %0h", n, row, a, e);
    end
  endtask
  task automatic chk_all(input logic e_req, input logic [15:0] e_addr, input logic [15:0] e_instr,
                         input logic [15:0] e_pc1, input logic e_val);
    chk("imem_req", 32'(imem_req), 32'(e_req));
    chk("imem_addr", 32'(imem_addr), 32'(e_addr));
    chk("instr_d", 32'(instr_d), 32'(e_instr));
    chk("pc_plus1_d", 32'(pc_plus1_d), 32'(e_pc1));
    chk("valid_d", 32'(valid_d), 32'(e_val));
  endtask
  initial begin
    vecs[0]  = mk(0, 16'h0000, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0);
    vecs[1]  = mk(0, 16'h0000, 0, 1, 1, 16'h0000, 16'h0000, 16'h0000, 0);
    vecs[2]  = mk(0, 16'h0000, 0, 1, 1, 16'h0001, w(16'h0000), 16'h0001, 1);
    vecs[3]  = mk(0, 16'h0000, 0, 1, 1, 16'h0002, w(16'h0001), 16'h0002, 1);
    vecs[4]  = mk(0, 16'h0000, 0, 1, 1, 16'h0003, w(16'h0002), 16'h0003, 1);
    vecs[5]  = mk(0, 16'h0000, 0, 1, 1, 16'h0004, w(16'h0003), 16'h0004, 1);
    vecs[6]  = mk(0, 16'h0000, 1, 1, 1, 16'h0005, w(16'h0004), 16'h0005, 1);
    vecs[7]  = mk(0, 16'h0000, 1, 1, 0, 16'h0006, w(16'h0004), 16'h0005, 1);
    vecs[8]  = mk(0, 16'h0000, 1, 1, 0, 16'h0006, w(16'h0004), 16'h0005, 1);
    vecs[9]  = mk(0, 16'h0000, 0, 1, 0, 16'h0006, w(16'h0004), 16'h0005, 1);
    vecs[10] = mk(0, 16'h0000, 0, 1, 1, 16'h0006, w(16'h0005), 16'h0006, 1);
    vecs[11] = mk(1, 16'h0040, 0, 1, 1, 16'h0007, w(16'h0006), 16'h0007, 1);
    vecs[12] = mk(0, 16'h0000, 0, 1, 1, 16'h0040, w(16'h0006), 16'h0007, 0);
    vecs[13] = mk(1, 16'h0010, 0, 1, 1, 16'h0041, w(16'h0040), 16'h0041, 1);
    vecs[14] = mk(1, 16'h0040, 0, 0, 1, 16'h0010, w(16'h0040), 16'h0041, 0);
    vecs[15] = mk(0, 16'h0000, 0, 0, 1, 16'h0010, w(16'h0040), 16'h0041, 0);
    vecs[16] = mk(0, 16'h0000, 0, 0, 1, 16'h0010, w(16'h0040), 16'h0041, 0);
    vecs[17] = mk(0, 16'h0000, 0, 1, 1, 16'h0010, w(16'h0040), 16'h0041, 0);
    vecs[18] = mk(0, 16'h0000, 0, 1, 1, 16'h0040, w(16'h0040), 16'h0041, 0);
    vecs[19] = mk(0, 16'h0000, 1, 1, 1, 16'h0041, w(16'h0040), 16'h0041, 1);
    vecs[20] = mk(1, 16'h0080, 1, 1, 0, 16'h0042, w(16'h0040), 16'h0041, 1);
    vecs[21] = mk(0, 16'h0000, 0, 1, 1, 16'h0080, w(16'h0040), 16'h0041, 0);
    vecs[22] = mk(0, 16'h0000, 0, 0, 1, 16'h0081, w(16'h0080), 16'h0081, 1);
    vecs[23] = mk(0, 16'h0000, 1, 0, 1, 16'h0081, w(16'h0080), 16'h0081, 0);
    vecs[24] = mk(0, 16'h0000, 0, 1, 1, 16'h0081, w(16'h0080), 16'h0081, 0);
    vecs[25] = mk(1, 16'hFFFF, 0, 1, 1, 16'h0082, w(16'h0081), 16'h0082, 1);
    vecs[26] = mk(0, 16'h0000, 0, 1, 1, 16'hFFFF, w(16'h0081), 16'h0082, 0);
    vecs[27] = mk(0, 16'h0000, 0, 1, 1, 16'h0000, w(16'hFFFF), 16'h0000, 1);
    vecs[28] = mk(0, 16'h0000, 0, 1, 1, 16'h0001, w(16'h0000), 16'h0001, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 29; i++) begin
      if (i > 0) @(negedge clk);
      row = i;
      PC_source = vecs[i].ps;
      branch_target_d = vecs[i].tgt;
      stall_f = vecs[i].st;
      imem_ready = vecs[i].rdy;
      #1;
      chk_all(vecs[i].e_req, vecs[i].e_addr, vecs[i].e_instr, vecs[i].e_pc1, vecs[i].e_val);
    end
    @(negedge clk);
    row = 100;
    PC_source = 1'b0;
    stall_f = 1'b0;
    imem_ready = 1'b0;
    #1;
    chk_all(1'b1, 16'h0002, w(16'h0001), 16'h0002, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    row = 101;
    chk_all(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    imem_ready = 1'b1;
    #1;
    row = 102;
    chk_all(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    #1;
    row = 103;
    chk_all(1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    #1;
    row = 104;
    chk_all(1'b1, 16'h0001, w(16'h0000), 16'h0001, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
